// File: rtl/mem_mapped_io_pkg.sv
// Shared definitions for the MEM-stage memory-mapped I/O block: window base,
// register word offsets and STATUS/CTRL bit positions.
package mmio_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1001_FFE0;

  typedef logic [2:0] wordOff_t;

  localparam wordOff_t OFF_PORT_OUT  = 3'd0;
  localparam wordOff_t OFF_PORT_IN   = 3'd1;
  localparam wordOff_t OFF_STATUS    = 3'd2;
  localparam wordOff_t OFF_TIMER     = 3'd3;
  localparam wordOff_t OFF_TIMER_CMP = 3'd4;
  localparam wordOff_t OFF_CTRL      = 3'd5;

  localparam int unsigned STATUS_IN_CHG  = 0;
  localparam int unsigned STATUS_TMR_HIT = 1;

  localparam int unsigned CTRL_TMR_EN     = 0;
  localparam int unsigned CTRL_AUTO_CLR   = 1;
  localparam int unsigned CTRL_IN_CHG_IE  = 2;
  localparam int unsigned CTRL_TMR_HIT_IE = 3;

  // The window is 32 bytes, so only Address[31:5] takes part in the match.
  function automatic logic inWindow(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:5] == base[31:5];
  endfunction

endpackage

// File: rtl/mem_mapped_io_if.sv
// MEM-stage bus between the pipeline and the memory-mapped I/O block.
interface mem_mapped_io_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic        IOHit;
  logic [31:0] IOReadData;
  logic        RAMWrite;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  IOHit, IOReadData, RAMWrite
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output IOHit, IOReadData, RAMWrite
  );
endinterface

// File: rtl/mem_mapped_io_input_sync_detect.sv
// Two-flop synchronizer for an asynchronous input bus with a change pulse.
module input_sync_detect #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut,
  output logic             changed
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= asyncIn;
      sync2 <= sync1;
    end
  end

  // High in the cycle before sync2 changes, so a flag registered from it
  // updates on the same edge as sync2.
  assign changed = |(sync1 ^ sync2);
  assign syncOut = sync2;

endmodule

// File: rtl/mem_mapped_io.sv
// Memory-mapped I/O register file for the MEM stage: output port, synchronized
// input port, sticky status, and a 32-bit timer with compare.
module mem_mapped_io
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE       = IO_BASE_DEFAULT,
  parameter int unsigned PORT_IN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_mapped_io_if.slave           bus,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [31:0]              PortOut,
  output logic                     Irq
);

  logic                     ioHit;
  logic                     wrEn;
  wordOff_t                 wordOff;
  logic [PORT_IN_WIDTH-1:0] portInSync;
  logic                     inChgPulse;
  logic [31:0]              portOutReg;
  logic [1:0]               status;
  logic [1:0]               statusNext;
  logic [31:0]              timer;
  logic [31:0]              timerCmp;
  logic [3:0]               ctrl;
  logic                     wrTimer;
  logic                     tmrMatch;
  logic [31:0]              readMux;
  logic                     unusedAddrBits;

  assign ioHit          = inWindow(bus.Address, IO_BASE);
  assign wordOff        = bus.Address[4:2];
  assign unusedAddrBits = ^bus.Address[1:0];
  assign wrEn           = bus.MemWrite & ioHit;
  assign wrTimer        = wrEn && (wordOff == OFF_TIMER);
  assign tmrMatch       = !wrTimer && ctrl[CTRL_TMR_EN] && (timer == timerCmp);

  input_sync_detect #(
    .WIDTH(PORT_IN_WIDTH)
  ) uInSync (
    .clk    (clk),
    .reset  (reset),
    .asyncIn(PortIn),
    .syncOut(portInSync),
    .changed(inChgPulse)
  );

  // Hardware set is OR-ed in after the W1C mask so a same-cycle set wins.
  always_comb begin
    logic [1:0] w1c;
    logic [1:0] hwSet;
    w1c = '0;
    hwSet = '0;
    if (wrEn && (wordOff == OFF_STATUS)) w1c = bus.WriteData[1:0];
    hwSet[STATUS_IN_CHG]  = inChgPulse;
    hwSet[STATUS_TMR_HIT] = tmrMatch;
    statusNext = (status & ~w1c) | hwSet;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      portOutReg <= '0;
      status     <= '0;
      timer      <= '0;
      timerCmp   <= '1;
      ctrl       <= '0;
    end else begin
      status <= statusNext;
      if (wrEn && (wordOff == OFF_PORT_OUT))  portOutReg <= bus.WriteData;
      if (wrEn && (wordOff == OFF_TIMER_CMP)) timerCmp   <= bus.WriteData;
      if (wrEn && (wordOff == OFF_CTRL))      ctrl       <= bus.WriteData[3:0];
      if (wrTimer) begin
        timer <= bus.WriteData;
      end else if (tmrMatch) begin
        timer <= ctrl[CTRL_AUTO_CLR] ? '0 : timer + 32'd1;
      end else if (ctrl[CTRL_TMR_EN]) begin
        timer <= timer + 32'd1;
      end
    end
  end

  always_comb begin
    readMux = '0;
    case (wordOff)
      OFF_PORT_OUT:  readMux = portOutReg;
      OFF_PORT_IN:   readMux = 32'(portInSync);
      OFF_STATUS:    readMux = {30'd0, status};
      OFF_TIMER:     readMux = timer;
      OFF_TIMER_CMP: readMux = timerCmp;
      OFF_CTRL:      readMux = {28'd0, ctrl};
      default:       readMux = '0;
    endcase
  end

  assign bus.IOHit      = ioHit;
  assign bus.IOReadData = (ioHit && bus.MemRead) ? readMux : '0;
  assign bus.RAMWrite   = bus.MemWrite & ~ioHit;
  assign PortOut        = portOutReg;
  assign Irq            = |(status & ctrl[CTRL_TMR_HIT_IE:CTRL_IN_CHG_IE]);

endmodule

// File: doc/mem_mapped_io.md
# mem_mapped_io

- Memory-mapped I/O peripheral for the MEM stage of the 5-stage MIPS pipeline; it sits beside DataMemory.
- It decodes the MEM-stage ALU byte address.
  - Matching word accesses go to a small register file: output port, synchronized input port, status flags, and a 32-bit timer with compare.
  - Data RAM writes are suppressed for any address the block claims.
- Read data is combinational, so it can feed the MEM/WB pipe in the same cycle as DataMemory output.

## Interface

Parameters
- IO_BASE, 32'h1001_FFE0: byte base address of the 32-byte I/O window (8 words). Must be 32-byte aligned.
- PORT_IN_WIDTH, 8: width of the external input port.

Ports
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; polarity and synchronicity fixed
- Address  input  32  MEM-stage ALU result, byte address
- WriteData  input  32  MEM-stage store data (forwarded rt value)
- MemWrite  input  1  MEM-stage store strobe
- MemRead  input  1  MEM-stage load strobe
- PortIn  input  PORT_IN_WIDTH  asynchronous external input pins
- IOHit  output  1  combinational; 1 when Address[31:5] == IO_BASE[31:5]
- IOReadData  output  32  combinational register read data; 0 when !IOHit or !MemRead
- RAMWrite  output  1  MemWrite & !IOHit; drives DataMemory MemWrite
- PortOut  output  32  PORT_OUT register value
- Irq  output  1  |(STATUS[1:0] & CTRL[3:2])

## Operation

Decode
- Word offset is Address[4:2]; Address[1:0] is ignored, so every access is treated as word-aligned.
- Offsets 6–7 are unmapped: they read 0 and ignore writes.

Register map (byte offset)
- 0x00 PORT_OUT: RW, reset 0.
- 0x04 PORT_IN: RO, {zero-extend, sync2}.
- 0x08 STATUS: bit0 IN_CHG, bit1 TMR_HIT.
  - Both bits are sticky, write-1-to-clear, reset 0.
  - Other bits read 0.
- 0x0C TIMER: RW 32-bit counter, reset 0.
- 0x10 TIMER_CMP: RW, reset 32'hFFFF_FFFF.
- 0x14 CTRL: bits[3:0] RW, reset 0.
  - bit0 TMR_EN.
  - bit1 AUTO_CLR.
  - bit2 IN_CHG_IE.
  - bit3 TMR_HIT_IE.
  - Other bits read 0.

Input path
- PortIn passes through two flops: sync1, then sync2.
- IN_CHG is set on any edge where next sync2 differs from current sync2.

Timer, per cycle, in priority order
- A software write to TIMER loads WriteData. No increment and no compare happen that cycle.
- Else, if TMR_EN and TIMER == TIMER_CMP:
  - TMR_HIT is set.
  - TIMER becomes 0 if AUTO_CLR, else TIMER + 1.
- Else, if TMR_EN: TIMER increments modulo 2^32; 32'hFFFF_FFFF wraps to 0.
- A write to CTRL takes effect on the following cycle.

Simultaneous events
- If a STATUS W1C and a hardware set hit the same bit in the same cycle, the set wins and the bit stays 1.

Read side effects
- Reads have no side effects.
- MemRead only gates IOReadData.

Stores inside the window
- Stores inside the window never reach DataMemory.

Mid-operation reset
- Reset mid-operation returns every register to its reset value on that edge.
- Both sync flops reset to 0.

## Timing

- Register writes commit at the rising edge that ends the MEM-stage cycle in which MemWrite && IOHit.
- The new value is visible on IOReadData and PortOut from the next cycle.
- Read latency is 0 cycles (combinational from Address and register state).
- PortIn change at pins before edge n:
  - sync1 updates at edge n.
  - sync2 and IN_CHG update at edge n+1.
  - PORT_IN read reflects the change from cycle n+1 onward.
- Irq is a function of registered state only; it is glitch-free relative to clk.
- Reset values:
  - PortOut = 0, Irq = 0.
  - IOHit, IOReadData and RAMWrite are purely combinational and therefore not registered.

## Structure

- Shared package `mmio_pkg` holds:
  - IO_BASE default.
  - Word-offset constants: OFF_PORT_OUT = 0, OFF_PORT_IN = 1, OFF_STATUS = 2, OFF_TIMER = 3, OFF_TIMER_CMP = 4, OFF_CTRL = 5.
  - STATUS/CTRL bit indices.
- One natural sub-module, `input_sync_detect`.
  - Parameterized width; 2-flop synchronizer plus change pulse.
  - Reused for any future input ports.
- Top-level integration:
  - MEM/WB data input selects IOReadData when IOHit, else DataMemory ReadData.
  - DataMemory MemWrite is driven by RAMWrite.

## Test plan

- **Reset, PortOut store, RAM suppression.**
  - Stimulus: assert reset, then store 32'hDEAD_BEEF to 0x1001_FFE0.
  - Required: PortOut = 0 during and after reset; PortOut = DEADBEEF on the cycle after the store; RAMWrite = 0.
  - Stimulus: store to 0x1001_0000.
  - Required: RAMWrite = 1, IOHit = 0.
- **Input sync and change flag.**
  - Stimulus: PortIn 8'h00 → 8'h5A before edge n.
  - Required: PORT_IN reads 0 at cycle n and 32'h5A at n+1.
  - Stimulus: with CTRL = 4'b0100, IN_CHG sets at n+1.
  - Required: Irq = 1; a write of 1 to STATUS clears both.
- **Timer compare with AUTO_CLR.**
  - Stimulus: TIMER_CMP = 3, CTRL = 4'b1011.
  - Required: TIMER sequence 0,1,2,3,0,1…; TMR_HIT set on the cycle after TIMER == 3; Irq = 1.
- **Wrap-around.**
  - Stimulus: load TIMER = FFFF_FFFE, TMR_EN = 1, CMP = 5.
  - Required: TIMER reads FFFF_FFFF, then 0, then 1; no TMR_HIT.
- **Collision and priority.**
  - Stimulus: a STATUS W1C of bit1 in the same cycle as a TIMER == CMP hit.
  - Required: TMR_HIT remains 1.
  - Stimulus: a TIMER write during enabled counting.
  - Required: the loaded value wins; no increment that cycle.
- **Unmapped, misaligned, and mid-operation reset.**
  - Stimulus: read offset 0x18; store to 0x1001_FFE2.
  - Required: offset 0x18 reads 0; the 0x...E2 store updates PORT_OUT.
  - Stimulus: reset asserted during timer count.
  - Required: TIMER = 0, CTRL = 0, STATUS = 0 next cycle.
